// File: rtl/pattern_sequencer_pkg.sv
// Shared definitions for the Sly-Man-Says pattern sequencer: FSM state encoding,
// colour codes and a counter-width helper.
package pattern_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPEND   = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_FAIL     = 3'd5,
        S_WIN      = 3'd6
    } state_t;

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] GRN = 2'd1;
    localparam logic [1:0] BLU = 2'd2;
    localparam logic [1:0] YEL = 2'd3;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Game-side signals of the pattern sequencer: LFSR input, start/button events,
// LED drive and status. The sequencer uses the slave modport.
interface pattern_sequencer_if #(
    parameter int MAX_LEN = 32
);
    localparam int W = $clog2(MAX_LEN + 1);

    logic [31:0]  random_num;
    logic         start;
    logic         btn_valid;
    logic [1:0]   btn_color;
    logic         led_en;
    logic [1:0]   led_color;
    logic         awaiting_input;
    logic [W-1:0] round_len;
    logic         game_over;
    logic         win;

    modport master (
        output random_num, start, btn_valid, btn_color,
        input  led_en, led_color, awaiting_input, round_len, game_over, win
    );

    modport slave (
        input  random_num, start, btn_valid, btn_color,
        output led_en, led_color, awaiting_input, round_len, game_over, win
    );

endinterface

// File: rtl/pattern_sequencer_seq_mem.sv
// Colour sequence storage: DEPTH x 2-bit register file, one synchronous write
// port and one asynchronous read port.
module pattern_sequencer_seq_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);

    logic [1:0] mem [DEPTH];

    // NOTE: no reset on the array; entries at or beyond the current length are never read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pattern_sequencer.sv
// Sly-Man-Says sequencer: grows a random colour sequence by one each round,
// plays it on the LED, then checks the player's presses against it.
module pattern_sequencer
    import pattern_sequencer_pkg::*;
#(
    parameter int MAX_LEN        = 32,
    parameter int LED_ON_CYCLES  = 25000000,
    parameter int LED_OFF_CYCLES = 12500000
) (
    input  logic                clk,
    input  logic                reset,
    pattern_sequencer_if.slave  bus
);

    localparam int W  = $clog2(MAX_LEN + 1);
    localparam int AW = cnt_width(MAX_LEN);
    localparam int TW = cnt_width((LED_ON_CYCLES > LED_OFF_CYCLES) ? LED_ON_CYCLES : LED_OFF_CYCLES);

    localparam logic [TW-1:0] ON_LAST  = TW'(LED_ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(LED_OFF_CYCLES - 1);
    localparam logic [W-1:0]  LEN_MAX  = W'(MAX_LEN);

    state_t        state;
    logic [W-1:0]  len;
    logic [W-1:0]  idx;
    logic [TW-1:0] timer;
    logic          led_en_q;
    logic          awaiting_q;
    logic          game_over_q;
    logic          win_q;
    logic [1:0]    cur_color;
    logic          last_idx;

    // Only the low two LFSR bits pick a colour.
    logic unused_rand_bits;
    assign unused_rand_bits = ^bus.random_num[31:2];

    assign last_idx = (idx == len - W'(1));

    pattern_sequencer_seq_mem #(
        .DEPTH(MAX_LEN),
        .AW   (AW)
    ) u_seq_mem (
        .clk  (clk),
        .we   (state == S_APPEND),
        .waddr(len[AW-1:0]),
        .wdata(bus.random_num[1:0]),
        .raddr(idx[AW-1:0]),
        .rdata(cur_color)
    );

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            len         <= '0;
            idx         <= '0;
            timer       <= '0;
            led_en_q    <= 1'b0;
            awaiting_q  <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FAIL, S_WIN: begin
                    if (bus.start) begin
                        state       <= S_APPEND;
                        len         <= '0;
                        idx         <= '0;
                        game_over_q <= 1'b0;
                        win_q       <= 1'b0;
                    end
                end
                S_APPEND: begin
                    len      <= len + W'(1);
                    idx      <= '0;
                    timer    <= '0;
                    led_en_q <= 1'b1;
                    state    <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (timer == ON_LAST) begin
                        timer    <= '0;
                        led_en_q <= 1'b0;
                        state    <= S_SHOW_OFF;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (timer == OFF_LAST) begin
                        timer <= '0;
                        if (last_idx) begin
                            idx        <= '0;
                            awaiting_q <= 1'b1;
                            state      <= S_WAIT_IN;
                        end else begin
                            idx      <= idx + W'(1);
                            led_en_q <= 1'b1;
                            state    <= S_SHOW_ON;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT_IN: begin
                    if (bus.btn_valid) begin
                        if (bus.btn_color != cur_color) begin
                            awaiting_q  <= 1'b0;
                            game_over_q <= 1'b1;
                            state       <= S_FAIL;
                        end else if (!last_idx) begin
                            idx <= idx + W'(1);
                        end else if (len == LEN_MAX) begin
                            awaiting_q <= 1'b0;
                            win_q      <= 1'b1;
                            state      <= S_WIN;
                        end else begin
                            idx        <= '0;
                            awaiting_q <= 1'b0;
                            state      <= S_APPEND;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Colour is forced dark whenever the LED is off, so it never leaks a sequence entry.
    assign bus.led_en         = led_en_q;
    assign bus.led_color      = led_en_q ? cur_color : 2'b00;
    assign bus.awaiting_input = awaiting_q;
    assign bus.round_len      = len;
    assign bus.game_over      = game_over_q;
    assign bus.win            = win_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed self-checking bench for pattern_sequencer with a short sequence and
// short LED timings; expected outputs are hand-derived for each step.
module tb_pattern_sequencer;
    import pattern_sequencer_pkg::*;

    localparam int MAX_LEN = 3;
    localparam int ON_CYC  = 3;
    localparam int OFF_CYC = 2;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pattern_sequencer_if #(.MAX_LEN(MAX_LEN)) bus ();

    pattern_sequencer #(
        .MAX_LEN       (MAX_LEN),
        .LED_ON_CYCLES (ON_CYC),
        .LED_OFF_CYCLES(OFF_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one edge; outputs are then observed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic le, input logic [1:0] lc,
                              input logic aw, input logic [1:0] rl,
                              input logic go, input logic wn);
        check({tag, ".led_en"},    32'(bus.led_en),         32'(le));
        check({tag, ".led_color"}, 32'(bus.led_color),      32'(lc));
        check({tag, ".awaiting"},  32'(bus.awaiting_input), 32'(aw));
        check({tag, ".round_len"}, 32'(bus.round_len),      32'(rl));
        check({tag, ".game_over"}, 32'(bus.game_over),      32'(go));
        check({tag, ".win"},       32'(bus.win),            32'(wn));
    endtask

    // Called right after the edge that entered SHOW_ON; returns right after the
    // edge that leaves the following SHOW_OFF.
    task automatic play(input string tag, input logic [1:0] c, input logic [1:0] rl);
        for (int i = 0; i < ON_CYC; i++) begin
            expect_out({tag, ".on"}, 1'b1, c, 1'b0, rl, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < OFF_CYC; i++) begin
            expect_out({tag, ".off"}, 1'b0, 2'b00, 1'b0, rl, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic press(input logic [1:0] c);
        bus.btn_valid = 1'b1;
        bus.btn_color = c;
        tick();
        bus.btn_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        bus.random_num = 32'h0;
        bus.start      = 1'b0;
        bus.btn_valid  = 1'b0;
        bus.btn_color  = 2'b00;
        tick();
        tick();
        expect_out("reset", 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("idle", 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);

        // Game 1, round 0: sequence {BLU}
        bus.random_num = 32'hDEAD_BEE2;
        pulse_start();
        expect_out("g1.append0", 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        play("g1.r0", BLU, 2'd1);
        expect_out("g1.r0.wait", 1'b0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0);

        // Round 1: sequence {BLU, GRN}
        bus.random_num = 32'h1234_5671;
        press(BLU);
        expect_out("g1.append1", 1'b0, 2'b00, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        play("g1.r1a", BLU, 2'd2);
        play("g1.r1b", GRN, 2'd2);
        expect_out("g1.r1.wait", 1'b0, 2'b00, 1'b1, 2'd2, 1'b0, 1'b0);
        press(BLU);
        expect_out("g1.r1.p0", 1'b0, 2'b00, 1'b1, 2'd2, 1'b0, 1'b0);

        // Round 2: sequence {BLU, GRN, YEL} reaches MAX_LEN
        bus.random_num = 32'hCAFE_F00F;
        press(GRN);
        expect_out("g1.append2", 1'b0, 2'b00, 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        play("g1.r2a", BLU, 2'd3);
        play("g1.r2b", GRN, 2'd3);
        play("g1.r2c", YEL, 2'd3);
        expect_out("g1.r2.wait", 1'b0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0);
        press(BLU);
        press(GRN);
        expect_out("g1.r2.p1", 1'b0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0);
        press(YEL);
        expect_out("g1.win", 1'b0, 2'b00, 1'b0, 2'd3, 1'b0, 1'b1);
        tick();
        expect_out("g1.win.hold", 1'b0, 2'b00, 1'b0, 2'd3, 1'b0, 1'b1);

        // start and btn_valid together in WIN: only the new game applies
        bus.random_num = 32'h0000_0002;
        bus.start      = 1'b1;
        bus.btn_valid  = 1'b1;
        bus.btn_color  = BLU;
        tick();
        bus.start     = 1'b0;
        bus.btn_valid = 1'b0;
        expect_out("g2.append", 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        play("g2.r0", BLU, 2'd1);
        expect_out("g2.wait", 1'b0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0);

        // Wrong press -> FAIL, later presses ignored
        press(RED);
        expect_out("g2.fail", 1'b0, 2'b00, 1'b0, 2'd1, 1'b1, 1'b0);
        press(BLU);
        expect_out("g2.fail.press", 1'b0, 2'b00, 1'b0, 2'd1, 1'b1, 1'b0);

        // New game from FAIL: sequence {GRN}
        bus.random_num = 32'h0000_0005;
        pulse_start();
        expect_out("g3.append", 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out("g3.on0", 1'b1, GRN, 1'b0, 2'd1, 1'b0, 1'b0);

        // Press and start during SHOW_ON are ignored; timing continues untouched
        bus.btn_valid = 1'b1;
        bus.btn_color = RED;
        bus.start     = 1'b1;
        tick();
        bus.btn_valid = 1'b0;
        bus.start     = 1'b0;
        expect_out("g3.on1", 1'b1, GRN, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        expect_out("g3.on2", 1'b1, GRN, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        expect_out("g3.off0", 1'b0, 2'b00, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        expect_out("g3.off1", 1'b0, 2'b00, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        expect_out("g3.wait", 1'b0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0);

        // start during WAIT_IN is ignored
        pulse_start();
        expect_out("g3.wait.start", 1'b0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0);

        // Round 2 begins, then reset mid-SHOW_ON
        bus.random_num = 32'h0000_0003;
        press(GRN);
        expect_out("g3.append1", 1'b0, 2'b00, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        expect_out("g3.r1.on0", 1'b1, GRN, 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        expect_out("g3.r1.on1", 1'b1, GRN, 1'b0, 2'd2, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_out("midreset", 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        press(GRN);
        expect_out("midreset.press", 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out("midreset.idle", 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);

        // start -> led_en high exactly two edges later
        bus.random_num = 32'hFFFF_FFFC;
        pulse_start();
        expect_out("g4.lat1", 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out("g4.lat2", 1'b1, RED, 1'b0, 2'd1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
